// File: rtl/pipe_reg_chain_pkg.sv
// Shared constants for the pipeline register chain: width helpers used to size
// the occupancy counter from the chain depth.
package pipe_reg_chain_pkg;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  // A one-stage chain still needs one bit to count 0..1.
  function automatic int occ_width(input int depth);
    int w;
    w = clog2(depth + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/pipe_reg_stage.sv
// One stage of the chain: a valid flag plus a data word that is only written
// when a valid word moves in, so bubbles never toggle the data register.
module pipe_reg_stage #(
  parameter int WORD_LENGTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   load,
  input  logic                   up_valid,
  input  logic [WORD_LENGTH-1:0] up_data,
  output logic                   valid,
  output logic [WORD_LENGTH-1:0] data
);

  logic                   valid_q;
  logic [WORD_LENGTH-1:0] data_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (load) begin
      valid_q <= up_valid;
      if (up_valid) data_q <= up_data;
    end
  end

  assign valid = valid_q;
  assign data  = data_q;

endmodule

// File: rtl/pipe_reg_chain.sv
// DEPTH-stage valid/ready register chain with bubble collapse, freeze, flush
// and a registered occupancy count.
module pipe_reg_chain
  import pipe_reg_chain_pkg::*;
#(
  parameter int WORD_LENGTH = 4,
  parameter int DEPTH       = 3,
  parameter int OCC_W       = occ_width(DEPTH)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WORD_LENGTH-1:0] Data_Input,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WORD_LENGTH-1:0] Data_Output,
  output logic [OCC_W-1:0]       occupancy
);

  logic                   adv;
  logic                   load      [DEPTH+1];
  logic                   stg_load  [DEPTH];
  logic                   up_valid  [DEPTH];
  logic                   stg_upv   [DEPTH];
  logic [WORD_LENGTH-1:0] up_data   [DEPTH];
  logic                   valid     [DEPTH];
  logic [WORD_LENGTH-1:0] data      [DEPTH];
  logic [OCC_W-1:0]       occ_d, occ_q;

  // Gating with reset keeps in_ready low while the chain is held in reset.
  assign adv         = reset & enable & ~flush;
  assign load[DEPTH] = out_ready;

  genvar i;
  generate
    for (i = 0; i < DEPTH; i++) begin : g_stage
      if (i == 0) begin : g_head
        assign up_valid[i] = in_valid;
        assign up_data[i]  = Data_Input;
      end else begin : g_body
        assign up_valid[i] = valid[i-1];
        assign up_data[i]  = data[i-1];
      end

      assign load[i]     = adv & (~valid[i] | load[i+1]);
      // Flush is a forced load of an empty slot: valid clears, data untouched.
      assign stg_load[i] = load[i] | flush;
      assign stg_upv[i]  = up_valid[i] & ~flush;

      pipe_reg_stage #(
        .WORD_LENGTH(WORD_LENGTH)
      ) u_stage (
        .clk      (clk),
        .reset    (reset),
        .load     (stg_load[i]),
        .up_valid (stg_upv[i]),
        .up_data  (up_data[i]),
        .valid    (valid[i]),
        .data     (data[i])
      );
    end
  endgenerate

  // Popcount of the valid bits each stage will hold after this edge.
  always_comb begin
    occ_d = '0;
    for (int k = 0; k < DEPTH; k++) begin
      occ_d = occ_d + OCC_W'(stg_load[k] ? stg_upv[k] : valid[k]);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) occ_q <= '0;
    else        occ_q <= occ_d;
  end

  assign in_ready    = load[0];
  assign out_valid   = valid[DEPTH-1];
  assign Data_Output = data[DEPTH-1];
  assign occupancy   = occ_q;

endmodule

// File: tb/tb_pipe_reg_chain.sv
// Directed, table-driven bench for a 3-deep, 4-bit pipe_reg_chain plus
// hand-written sequences for asynchronous reset in the middle of a transfer.
module tb_pipe_reg_chain;

  localparam int W = 4;
  localparam int D = 3;

  logic         clk;
  logic         reset;
  logic         enable;
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] Data_Input;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] Data_Output;
  logic [1:0]   occupancy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic         rst;
    logic         en;
    logic         fl;
    logic         iv;
    logic [W-1:0] din;
    logic         ordy;
    logic         exp_ir;
    logic         exp_ov;
    logic [W-1:0] exp_do;
    int           exp_occ;
  } vec_t;

  vec_t vecs[$];

  pipe_reg_chain #(
    .WORD_LENGTH(W),
    .DEPTH(D)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .Data_Input  (Data_Input),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .Data_Output (Data_Output),
    .occupancy   (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Occupancy may never exceed the depth.
  always @(negedge clk) begin
    checks++;
    if (int'(occupancy) > D) begin
      errors++;
      $display("FAIL occ_bound actual=%0d limit=%0d at %0t", occupancy, D, $time);
    end
  end

  task automatic add(input logic rst, input logic en, input logic fl, input logic iv,
                     input logic [W-1:0] din, input logic ordy, input logic ir,
                     input logic ov, input logic [W-1:0] dout, input int occ);
    vec_t v;
    v.rst = rst; v.en = en; v.fl = fl; v.iv = iv; v.din = din; v.ordy = ordy;
    v.exp_ir = ir; v.exp_ov = ov; v.exp_do = dout; v.exp_occ = occ;
    vecs.push_back(v);
  endtask

  initial begin
    reset = 1'b0; enable = 1'b1; flush = 1'b0;
    in_valid = 1'b0; Data_Input = '0; out_ready = 1'b0;

    // rst en fl iv din ordy | in_ready(pre-edge) out_valid Data_Output occupancy(post-edge)
    add(0,1,0,1,4'hA,1, 0,0,4'h0,0);   // held in reset
    add(1,1,0,0,4'h0,1, 1,0,4'h0,0);   // released
    // streaming, latency 3
    add(1,1,0,1,4'h1,1, 1,0,4'h0,1);
    add(1,1,0,1,4'h2,1, 1,0,4'h0,2);
    add(1,1,0,1,4'h3,1, 1,1,4'h1,3);
    add(1,1,0,1,4'h4,1, 1,1,4'h2,3);
    add(1,1,0,0,4'h0,1, 1,1,4'h3,2);
    add(1,1,0,0,4'h0,1, 1,1,4'h4,1);
    add(1,1,0,0,4'h0,1, 1,0,4'h4,0);   // output data holds when empty
    // back-pressure
    add(1,1,0,1,4'h7,0, 1,0,4'h4,1);
    add(1,1,0,1,4'h8,0, 1,0,4'h4,2);
    add(1,1,0,1,4'h9,0, 1,1,4'h7,3);
    add(1,1,0,1,4'hB,0, 0,1,4'h7,3);
    add(1,1,0,1,4'hB,0, 0,1,4'h7,3);
    add(1,1,0,1,4'hB,1, 1,1,4'h8,3);   // one out, one in
    add(1,1,0,0,4'h0,1, 1,1,4'h9,2);
    add(1,1,0,0,4'h0,1, 1,1,4'hB,1);
    add(1,1,0,0,4'h0,1, 1,0,4'hB,0);
    // bubble collapse under stall
    add(1,1,0,1,4'h5,0, 1,0,4'hB,1);
    add(1,1,0,0,4'h0,0, 1,0,4'hB,1);
    add(1,1,0,0,4'h0,0, 1,1,4'h5,1);
    add(1,1,0,1,4'h6,0, 1,1,4'h5,2);
    add(1,1,0,0,4'h0,0, 1,1,4'h5,2);
    // freeze
    add(1,0,0,1,4'hD,1, 0,1,4'h5,2);
    add(1,0,0,1,4'hD,1, 0,1,4'h5,2);
    add(1,0,0,1,4'hD,1, 0,1,4'h5,2);
    add(1,0,0,1,4'hD,1, 0,1,4'h5,2);
    add(1,1,0,0,4'h0,1, 1,1,4'h6,1);
    add(1,1,0,0,4'h0,1, 1,0,4'h6,0);
    // fill, then flush
    add(1,1,0,1,4'h1,0, 1,0,4'h6,1);
    add(1,1,0,1,4'h2,0, 1,0,4'h6,2);
    add(1,1,0,1,4'h3,0, 1,1,4'h1,3);
    add(1,1,1,1,4'hE,1, 0,0,4'h1,0);
    add(1,1,0,0,4'h0,0, 1,0,4'h1,0);
    // refill two words
    add(1,1,0,1,4'h9,0, 1,0,4'h1,1);
    add(1,1,0,1,4'hA,0, 1,0,4'h1,2);

    for (int n = 0; n < vecs.size(); n++) begin
      @(negedge clk);
      reset = vecs[n].rst; enable = vecs[n].en; flush = vecs[n].fl;
      in_valid = vecs[n].iv; Data_Input = vecs[n].din; out_ready = vecs[n].ordy;
      #1;
      chk($sformatf("in_ready[%0d]", n), int'(in_ready), int'(vecs[n].exp_ir));
      @(posedge clk);
      #1;
      chk($sformatf("out_valid[%0d]", n), int'(out_valid), int'(vecs[n].exp_ov));
      chk($sformatf("data_out[%0d]", n), int'(Data_Output), int'(vecs[n].exp_do));
      chk($sformatf("occupancy[%0d]", n), int'(occupancy), vecs[n].exp_occ);
    end

    // Asynchronous reset between edges while two words are in flight.
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    #2 reset = 1'b0;
    #1;
    chk("async_rst_ov", int'(out_valid), 0);
    chk("async_rst_do", int'(Data_Output), 0);
    chk("async_rst_occ", int'(occupancy), 0);
    chk("async_rst_ir", int'(in_ready), 0);
    @(posedge clk);
    #1;
    chk("rst_hold_ov", int'(out_valid), 0);

    // Release and confirm dropped words never appear; a new word has latency 3.
    @(negedge clk);
    reset = 1'b1; in_valid = 1'b1; Data_Input = 4'hC; out_ready = 1'b1;
    #1;
    chk("post_rst_ir", int'(in_ready), 1);
    for (int c = 1; c <= 3; c++) begin
      @(posedge clk);
      #1;
      chk($sformatf("post_rst_ov[%0d]", c), int'(out_valid), (c == 3) ? 1 : 0);
      @(negedge clk);
      in_valid = 1'b0;
    end
    chk("post_rst_do", int'(Data_Output), 4'hC);
    chk("post_rst_occ", int'(occupancy), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout reached at %0t", $time);
    $fatal(1, "timeout");
  end

endmodule
